// File: rtl/mux_pipe_reg.sv
// Select one of NUM_IN data channels and register it behind a single pipeline stage
// with flush/stall control, a sticky illegal-select flag and a saturating stall-run counter.
module mux_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        stall_run
);

  logic [WIDTH-1:0] picked;
  logic             sel_legal;
  logic             load;

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] run_q, run_d;

  // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    picked    = '0;
    sel_legal = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        picked    = in_bus[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign load = !flush && !stall;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (flush) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      out_d   = picked;
      valid_d = in_valid;
    end
  end

  assign err_d = err_q || (load && in_valid && !sel_legal);

  // Counter saturates at all-ones instead of wrapping.
  always_comb begin
    run_d = '0;
    if (stall && !flush) begin
      run_d = (run_q == {CNT_W{1'b1}}) ? run_q : run_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;
  assign stall_run = run_q;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: directed scenarios plus a randomized sweep of four
// parameter configurations against a rule-level reference model.
module tb_mux_pipe_reg;

  logic clk;
  logic reset;
  logic in_valid, stall, flush;

  // A: 32b x4, 3-bit select (sel 4..7 illegal)
  logic [127:0] in_bus_a;
  logic [2:0]   sel_a;
  logic [31:0]  out_a;
  logic         val_a, err_a;
  logic [7:0]   run_a;
  // B: 32b x3, 2-bit select, 3-bit counter
  logic [95:0]  in_bus_b;
  logic [1:0]   sel_b;
  logic [31:0]  out_b;
  logic         val_b, err_b;
  logic [2:0]   run_b;
  // C: 8b x16, 4-bit select (all legal)
  logic [127:0] in_bus_c;
  logic [3:0]   sel_c;
  logic [7:0]   out_c;
  logic         val_c, err_c;
  logic [7:0]   run_c;
  // D: 64b x2, 1-bit select (all legal)
  logic [127:0] in_bus_d;
  logic [0:0]   sel_d;
  logic [63:0]  out_d;
  logic         val_d, err_d;
  logic [7:0]   run_d;

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(3), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .in_bus(in_bus_a), .sel(sel_a), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_a), .out_valid(val_a), .sel_err(err_a),
    .stall_run(run_a));
  mux_pipe_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(3)) u_b (
    .clk(clk), .reset(reset), .in_bus(in_bus_b), .sel(sel_b), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_b), .out_valid(val_b), .sel_err(err_b),
    .stall_run(run_b));
  mux_pipe_reg #(.WIDTH(8), .NUM_IN(16), .SEL_W(4), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .in_bus(in_bus_c), .sel(sel_c), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_c), .out_valid(val_c), .sel_err(err_c),
    .stall_run(run_c));
  mux_pipe_reg #(.WIDTH(64), .NUM_IN(2), .SEL_W(1), .CNT_W(8)) u_d (
    .clk(clk), .reset(reset), .in_bus(in_bus_d), .sel(sel_d), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out_d), .out_valid(val_d), .sel_err(err_d),
    .stall_run(run_d));

  localparam int W_P    [4] = '{32, 32, 8, 64};
  localparam int N_P    [4] = '{4, 3, 16, 2};
  localparam int SW_P   [4] = '{3, 2, 4, 1};
  localparam int RMAX_P [4] = '{255, 7, 255, 255};

  logic [63:0] g_out [4];
  logic        g_val [4];
  logic        g_err [4];
  logic [7:0]  g_run [4];

  always_comb begin
    g_out[0] = {32'd0, out_a}; g_val[0] = val_a; g_err[0] = err_a; g_run[0] = run_a;
    g_out[1] = {32'd0, out_b}; g_val[1] = val_b; g_err[1] = err_b; g_run[1] = {5'd0, run_b};
    g_out[2] = {56'd0, out_c}; g_val[2] = val_c; g_err[2] = err_c; g_run[2] = run_c;
    g_out[3] = out_d;          g_val[3] = val_d; g_err[3] = err_d; g_run[3] = run_d;
  end

  typedef struct {
    logic [63:0] out;
    bit          valid;
    bit          err;
    int          run;
  } mstate_t;

  mstate_t m [4];
  int n_cmp = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick(logic [255:0] bus, int s, int w, int n);
    logic [63:0] r = '0;
    if (s < n)
      for (int b = 0; b < w; b++) r[b] = bus[s*w + b];
    return r;
  endfunction

  task automatic test_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 4;
      if (g_out[i] !== 64'd0) begin n_err++; $display("FAIL reset_out[%0d]: got %h expected 0", i, g_out[i]); end
      if (g_val[i] !== 1'b0)  begin n_err++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, g_val[i]); end
      if (g_err[i] !== 1'b0)  begin n_err++; $display("FAIL reset_err[%0d]: got %b expected 0", i, g_err[i]); end
      if (g_run[i] !== 8'd0)  begin n_err++; $display("FAIL reset_run[%0d]: got %0d expected 0", i, g_run[i]); end
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load();
    in_bus_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel_a = 3'd2; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    n_cmp += 2;
    if (out_a !== 32'h33333333) begin n_err++; $display("FAIL load_sel2: got %h expected 33333333", out_a); end
    if (val_a !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b expected 1", val_a); end
    sel_a = 3'd0;
    tick();
    n_cmp++;
    if (out_a !== 32'h11111111) begin n_err++; $display("FAIL load_sel0: got %h expected 11111111", out_a); end
  endtask

  task automatic test_stall_flush();
    sel_a = 3'd1;
    tick();
    n_cmp++;
    if (out_a !== 32'h22222222) begin n_err++; $display("FAIL pre_stall_load: got %h expected 22222222", out_a); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel_a = 3'(i * 3);
      tick();
      n_cmp += 3;
      if (out_a !== 32'h22222222) begin n_err++; $display("FAIL stall_hold_out: got %h expected 22222222", out_a); end
      if (val_a !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid: got %b expected 1", val_a); end
      if (run_a !== 8'(i + 1)) begin n_err++; $display("FAIL stall_run: got %0d expected %0d", run_a, i + 1); end
    end
    flush = 1'b1;
    tick();
    n_cmp += 3;
    if (out_a !== 32'd0) begin n_err++; $display("FAIL flush_out: got %h expected 0", out_a); end
    if (val_a !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", val_a); end
    if (run_a !== 8'd0) begin n_err++; $display("FAIL flush_run: got %0d expected 0", run_a); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_illegal_sel();
    reset = 1'b1; #1; reset = 1'b0;
    in_bus_b = {32'h33333333, 32'h22222222, 32'h11111111};
    sel_b = 2'd3; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    n_cmp += 3;
    if (out_b !== 32'd0) begin n_err++; $display("FAIL illegal_out: got %h expected 0", out_b); end
    if (val_b !== 1'b0) begin n_err++; $display("FAIL illegal_novalid_valid: got %b expected 0", val_b); end
    if (err_b !== 1'b0) begin n_err++; $display("FAIL illegal_novalid_err: got %b expected 0", err_b); end
    in_valid = 1'b1; stall = 1'b1;
    tick();
    n_cmp++;
    if (err_b !== 1'b0) begin n_err++; $display("FAIL illegal_stalled_err: got %b expected 0", err_b); end
    stall = 1'b0; flush = 1'b1;
    tick();
    n_cmp++;
    if (err_b !== 1'b0) begin n_err++; $display("FAIL illegal_flushed_err: got %b expected 0", err_b); end
    flush = 1'b0;
    tick();
    n_cmp += 3;
    if (out_b !== 32'd0) begin n_err++; $display("FAIL illegal_load_out: got %h expected 0", out_b); end
    if (val_b !== 1'b1) begin n_err++; $display("FAIL illegal_load_valid: got %b expected 1", val_b); end
    if (err_b !== 1'b1) begin n_err++; $display("FAIL illegal_load_err: got %b expected 1", err_b); end
    sel_b = 2'd1;
    tick();
    n_cmp += 2;
    if (out_b !== 32'h22222222) begin n_err++; $display("FAIL legal_after_out: got %h expected 22222222", out_b); end
    if (err_b !== 1'b1) begin n_err++; $display("FAIL sticky_err: got %b expected 1", err_b); end
    sel_b = 2'd0; in_valid = 1'b0;
    tick();
    n_cmp++;
    if (err_b !== 1'b1) begin n_err++; $display("FAIL sticky_err2: got %b expected 1", err_b); end
  endtask

  task automatic test_saturation();
    reset = 1'b1; #1; reset = 1'b0;
    stall = 1'b1; flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (run_b !== 3'((i + 1 < 7) ? i + 1 : 7)) begin
        n_err++; $display("FAIL saturate_run edge %0d: got %0d expected %0d", i, run_b, (i + 1 < 7) ? i + 1 : 7);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (run_b !== 3'd0) begin n_err++; $display("FAIL saturate_clear: got %0d expected 0", run_b); end
  endtask

  task automatic test_async_reset();
    reset = 1'b1; #1; reset = 1'b0;
    in_bus_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel_a = 3'd5; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    n_cmp += 2;
    if (err_a !== 1'b1) begin n_err++; $display("FAIL areset_seterr: got %b expected 1", err_a); end
    if (out_a !== 32'd0) begin n_err++; $display("FAIL areset_illegal_out: got %h expected 0", out_a); end
    sel_a = 3'd3;
    tick();
    n_cmp++;
    if (out_a !== 32'h44444444) begin n_err++; $display("FAIL areset_preload: got %h expected 44444444", out_a); end
    #2 reset = 1'b1;
    #1;
    n_cmp += 4;
    if (out_a !== 32'd0) begin n_err++; $display("FAIL areset_out: got %h expected 0", out_a); end
    if (val_a !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b expected 0", val_a); end
    if (err_a !== 1'b0) begin n_err++; $display("FAIL areset_err: got %b expected 0", err_a); end
    if (run_a !== 8'd0) begin n_err++; $display("FAIL areset_run: got %0d expected 0", run_a); end
    sel_a = 3'd1;
    #1 reset = 1'b0;
    tick();
    n_cmp += 3;
    if (out_a !== 32'h22222222) begin n_err++; $display("FAIL areset_release_out: got %h expected 22222222", out_a); end
    if (val_a !== 1'b1) begin n_err++; $display("FAIL areset_release_valid: got %b expected 1", val_a); end
    if (err_a !== 1'b0) begin n_err++; $display("FAIL areset_release_err: got %b expected 0", err_a); end
  endtask

  task automatic test_sweep(int cycles);
    logic [255:0] bus [4];
    int          sv [4];
    logic [63:0] pk;
    bit          do_rst;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = '{out: '0, valid: 1'b0, err: 1'b0, run: 0};
    for (int c = 0; c < cycles; c++) begin
      do_rst   = ($urandom_range(0, 99) == 0);
      in_valid = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 4; i++) begin
        for (int w = 0; w < 8; w++) bus[i][w*32 +: 32] = $urandom;
        sv[i] = int'($urandom_range(0, (1 << SW_P[i]) - 1));
      end
      in_bus_a = bus[0][127:0]; sel_a = 3'(sv[0]);
      in_bus_b = bus[1][95:0];  sel_b = 2'(sv[1]);
      in_bus_c = bus[2][127:0]; sel_c = 4'(sv[2]);
      in_bus_d = bus[3][127:0]; sel_d = 1'(sv[3]);
      reset = do_rst;
      for (int i = 0; i < 4; i++) begin
        if (do_rst) begin
          m[i] = '{out: '0, valid: 1'b0, err: 1'b0, run: 0};
        end else begin
          pk = pick(bus[i], sv[i], W_P[i], N_P[i]);
          if (flush) begin
            m[i].out = '0; m[i].valid = 1'b0;
          end else if (!stall) begin
            m[i].out = pk; m[i].valid = in_valid;
            if (in_valid && sv[i] >= N_P[i]) m[i].err = 1'b1;
          end
          if (stall && !flush) m[i].run = (m[i].run < RMAX_P[i]) ? m[i].run + 1 : m[i].run;
          else m[i].run = 0;
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp += 4;
        if (g_out[i] !== m[i].out) begin n_err++; $display("FAIL sweep_out[%0d] cyc %0d: got %h expected %h", i, c, g_out[i], m[i].out); end
        if (g_val[i] !== m[i].valid) begin n_err++; $display("FAIL sweep_valid[%0d] cyc %0d: got %b expected %b", i, c, g_val[i], m[i].valid); end
        if (g_err[i] !== m[i].err) begin n_err++; $display("FAIL sweep_err[%0d] cyc %0d: got %b expected %b", i, c, g_err[i], m[i].err); end
        if (g_run[i] !== 8'(m[i].run)) begin n_err++; $display("FAIL sweep_run[%0d] cyc %0d: got %0d expected %0d", i, c, g_run[i], m[i].run); end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    in_bus_a = '0; in_bus_b = '0; in_bus_c = '0; in_bus_d = '0;
    sel_a = '0; sel_b = '0; sel_c = '0; sel_d = '0;
    test_reset();
    test_load();
    test_stall_flush();
    test_illegal_sel();
    test_saturation();
    test_async_reset();
    test_sweep(10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe_reg.md
MUX_PIPE_REG -- requirements
Module: mux_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of each data channel and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4, legal range 2..16: number of input channels.
REQ-003 The block SHALL have parameter SEL_W, default 2: select width, at least ceil(log2(NUM_IN)).
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the stall-run counter.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_bus, input, NUM_IN*WIDTH: concatenated channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-008 The block SHALL have port sel, input, SEL_W: channel select.
REQ-009 The block SHALL have port in_valid, input, 1: the presented data is a real instruction/operand.
REQ-010 The block SHALL have port stall, input, 1: freeze the register.
REQ-011 The block SHALL have port flush, input, 1: insert a bubble.
REQ-012 The block SHALL have port out, output, WIDTH: registered selected data.
REQ-013 The block SHALL have port out_valid, output, 1: registered valid.
REQ-014 The block SHALL have port sel_err, output, 1: sticky out-of-range-select flag.
REQ-015 The block SHALL have port stall_run, output, CNT_W: count of consecutive stall cycles.

Function
REQ-016 The block SHALL combinationally pick channel sel from in_bus; when sel >= NUM_IN, the picked value SHALL be all zeros.
REQ-017 The block SHALL have one cycle of latency: data picked in cycle n SHALL appear on out in cycle n+1 when loaded.
REQ-018 At each rising edge, the block SHALL apply this priority: flush > stall > load.
REQ-019 Flush: out SHALL become 0 and out_valid SHALL become 0, regardless of stall.
REQ-020 Stall without flush: out and out_valid SHALL hold their current values.
REQ-021 Load (neither flush nor stall): out SHALL take the picked value and out_valid SHALL take in_valid.
REQ-022 sel_err SHALL be set on any edge where in_valid=1, sel >= NUM_IN, and the register loads; once set, it SHALL remain 1 until reset.
REQ-023 A flushed or stalled cycle with an illegal sel SHALL NOT set sel_err.
REQ-024 stall_run SHALL increment on each edge with stall=1 and flush=0, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-025 stall_run SHALL clear to 0 on any edge with stall=0 or flush=1.
REQ-026 When NUM_IN equals 2^SEL_W, no select is illegal and sel_err SHALL stay 0.
REQ-027 The block SHALL be fully synthesizable, with no latches and no combinational path from inputs to outputs.

Reset
REQ-028 While reset=1, independent of clk, the block SHALL drive out=0, out_valid=0, sel_err=0, stall_run=0.
REQ-029 Deassertion of reset SHALL take effect at the first rising edge after release, following REQ-018.
REQ-030 Reset asserted mid-stall SHALL discard the held data and the count; there SHALL be no recovery of prior state.

Verification
REQ-031 Load: NUM_IN=4, channels 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1, one edge -> out=0x33333333, out_valid=1; sel=0 next edge -> out=0x11111111.
REQ-032 Stall/flush priority: loaded 0x22222222, then stall=1 for 3 edges with sel changing -> out=0x22222222, stall_run=3; then stall=1 and flush=1 -> out=0, out_valid=0, stall_run=0.
REQ-033 Illegal select: NUM_IN=3, SEL_W=2, sel=3, in_valid=1, load -> out=0, sel_err=1; legal loads afterwards keep sel_err=1; the same stimulus with in_valid=0 or stall=1 leaves sel_err=0.
REQ-034 Saturation: CNT_W=3, stall=1 for 10 edges -> stall_run reads 1..7 then holds 7; stall=0 for one edge -> 0.
REQ-035 Async reset: assert reset between clock edges while out=0x44444444 and sel_err=1 -> all outputs 0 before the next edge; release reset with sel=1 -> out=0x22222222 after one edge.
REQ-036 Parameter sweep: WIDTH=8/NUM_IN=16/SEL_W=4 and WIDTH=64/NUM_IN=2/SEL_W=1, randomized sel/stall/flush/in_valid compared against a cycle-accurate reference model for 10,000 cycles -> zero mismatches.
